gray_checker: RTL and testbench

//   Downstream monitor for the 3-bit Gray counter stage. Samples the counter's Output/Overflow pair,

---
 rtl/gray_checker.sv | 151 +++++++++++++++
 tb/tb_gray_checker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_checker.sv
// Downstream monitor for a Gray counter: decodes samples, checks single steps, counts wraps and resyncs.
// Optional hold-timeout detection is compiled in with GRAY_CHECKER_STALL_EN.
module gray_checker #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned WRAP_W    = 8,
  parameter int unsigned STALL_MAX = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Valid,
  input  logic [WIDTH-1:0]  GrayIn,
  input  logic              OvfIn,
  input  logic              Clear,
  output logic [WIDTH-1:0]  BinOut,
  output logic [WRAP_W-1:0] Wraps,
  output logic [WRAP_W-1:0] Resyncs,
  output logic              Err,
  output logic [1:0]        ErrCode,
  output logic              Stall
);

  typedef enum logic [1:0] {INIT, TRACK, ERR} state_t;
  typedef enum logic [1:0] {
    C_NONE      = 2'b00,
    C_JUMP      = 2'b01,
    C_OVF_EARLY = 2'b10,
    C_OVF_DROP  = 2'b11
  } code_t;
  typedef enum logic [2:0] {K_HOLD, K_RESYNC, K_WRAP, K_STEP, K_DROP, K_EARLY, K_JUMP} kind_t;

  localparam logic [WIDTH-1:0] MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] prev;
  logic             prev_ovf;
  kind_t            kind;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bin[i] = ^(GrayIn >> i);
    end
  end

  always_comb begin
    kind = K_JUMP;
    if (bin == prev && OvfIn == prev_ovf)
      kind = K_HOLD;
    else if (bin == '0 && !OvfIn && (prev != '0 || prev_ovf))
      kind = K_RESYNC;
    else if (prev == MAX && bin == '0 && OvfIn)
      kind = K_WRAP;
    else if (prev != MAX && bin == prev + WIDTH'(1) && OvfIn == prev_ovf)
      kind = K_STEP;
    else if (prev_ovf && !OvfIn)
      kind = K_DROP;
    else if (!prev_ovf && OvfIn)
      kind = K_EARLY;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= INIT;
      BinOut   <= '0;
      Wraps    <= '0;
      Resyncs  <= '0;
      Err      <= 1'b0;
      ErrCode  <= C_NONE;
      prev     <= '0;
      prev_ovf <= 1'b0;
    end else if (Clear) begin
      // Only the error state falls back to INIT; tracking continues otherwise.
      Err     <= 1'b0;
      ErrCode <= C_NONE;
      if (state == ERR) state <= INIT;
    end else if (Valid) begin
      unique case (state)
        INIT: begin
          prev     <= bin;
          prev_ovf <= OvfIn;
          BinOut   <= bin;
          state    <= TRACK;
        end
        TRACK: begin
          unique case (kind)
            K_HOLD: ;
            K_RESYNC: begin
              if (Resyncs != '1) Resyncs <= Resyncs + WRAP_W'(1);
              Wraps    <= '0;
              prev     <= '0;
              prev_ovf <= 1'b0;
              BinOut   <= '0;
            end
            K_WRAP: begin
              if (Wraps != '1) Wraps <= Wraps + WRAP_W'(1);
              prev     <= '0;
              prev_ovf <= 1'b1;
              BinOut   <= '0;
            end
            K_STEP: begin
              prev   <= bin;
              BinOut <= bin;
            end
            K_DROP: begin
              Err     <= 1'b1;
              ErrCode <= C_OVF_DROP;
              state   <= ERR;
            end
            K_EARLY: begin
              Err     <= 1'b1;
              ErrCode <= C_OVF_EARLY;
              state   <= ERR;
            end
            default: begin
              Err     <= 1'b1;
              ErrCode <= C_JUMP;
              state   <= ERR;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef GRAY_CHECKER_STALL_EN
  localparam int unsigned SW = $clog2(STALL_MAX + 1);
  logic [SW-1:0] stall_cnt;

  always_ff @(posedge Clk) begin
    if (!Reset_n || Clear) begin
      stall_cnt <= '0;
    end else if (Valid) begin
      if (state == TRACK && kind == K_HOLD) begin
        if (stall_cnt < SW'(STALL_MAX)) stall_cnt <= stall_cnt + SW'(1);
      end else begin
        stall_cnt <= '0;
      end
    end
  end

  assign Stall = (stall_cnt >= SW'(STALL_MAX));
`else
  logic unused_stall_cfg;
  assign unused_stall_cfg = |32'(STALL_MAX);
  assign Stall = 1'b0;
`endif

endmodule

// File: tb/tb_gray_checker.sv
// Directed bench for gray_checker: a rule-level reference model checked every cycle,
// plus literal expectations taken from hand-worked sequences.
module tb_gray_checker;

  localparam int SMAX = 4;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Valid = 1'b0;
  logic [2:0] GrayIn = '0;
  logic       OvfIn = 1'b0;
  logic       Clear = 1'b0;
  logic [2:0] BinOut;
  logic [7:0] Wraps;
  logic [7:0] Resyncs;
  logic       Err;
  logic [1:0] ErrCode;
  logic       Stall;

  gray_checker #(.WIDTH(3), .WRAP_W(8), .STALL_MAX(SMAX)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Valid(Valid), .GrayIn(GrayIn), .OvfIn(OvfIn),
    .Clear(Clear), .BinOut(BinOut), .Wraps(Wraps), .Resyncs(Resyncs), .Err(Err),
    .ErrCode(ErrCode), .Stall(Stall)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [2:0] G(int b);
    logic [2:0] v;
    v = 3'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int decode(logic [2:0] g);
    for (int k = 0; k < 8; k++) if (G(k) == g) return k;
    return -1;
  endfunction

  // Reference model: state is "synced" (a sample has been taken) and "err".
  bit started = 0;
  bit m_synced, m_err, m_ovf;
  int m_bin, m_wraps, m_resyncs, m_code, m_holds;

  always @(posedge Clk) begin
    int b;
    if (!Reset_n) begin
      started = 1; m_synced = 0; m_err = 0; m_ovf = 0;
      m_bin = 0; m_wraps = 0; m_resyncs = 0; m_code = 0; m_holds = 0;
    end else if (Clear) begin
      if (m_err) m_synced = 0;
      m_err = 0; m_code = 0; m_holds = 0;
    end else if (Valid && !m_err) begin
      b = decode(GrayIn);
      if (!m_synced) begin
        m_synced = 1; m_bin = b; m_ovf = OvfIn; m_holds = 0;
      end else if (b == m_bin && OvfIn == m_ovf) begin
        if (m_holds < SMAX) m_holds++;
      end else begin
        m_holds = 0;
        if (b == 0 && !OvfIn && (m_bin != 0 || m_ovf)) begin
          if (m_resyncs < 255) m_resyncs++;
          m_wraps = 0; m_bin = 0; m_ovf = 0;
        end else if (m_bin == 7 && b == 0 && OvfIn) begin
          if (m_wraps < 255) m_wraps++;
          m_bin = 0; m_ovf = 1;
        end else if (b == m_bin + 1 && OvfIn == m_ovf) begin
          m_bin = b;
        end else begin
          m_err = 1;
          if (m_ovf && !OvfIn) m_code = 3;
          else if (!m_ovf && OvfIn) m_code = 2;
          else m_code = 1;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (started) begin
      chk("m_BinOut", BinOut, m_bin);
      chk("m_Wraps", Wraps, m_wraps);
      chk("m_Resyncs", Resyncs, m_resyncs);
      chk("m_Err", Err, m_err);
      chk("m_ErrCode", ErrCode, m_code);
`ifdef GRAY_CHECKER_STALL_EN
      chk("m_Stall", Stall, m_holds >= SMAX);
`else
      chk("m_Stall", Stall, 0);
`endif
    end
  end

  task automatic cyc(input logic v, input logic [2:0] g, input logic o,
                     input logic c = 1'b0, input logic r = 1'b1);
    Valid = v; GrayIn = g; OvfIn = o; Clear = c; Reset_n = r;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_BinOut", BinOut, 0);
    chk("rst_Wraps", Wraps, 0);
    chk("rst_Resyncs", Resyncs, 0);
    chk("rst_Err", Err, 0);
    chk("rst_ErrCode", ErrCode, 0);
    chk("rst_Stall", Stall, 0);

    cyc(1'b1, G(0), 1'b0);
    chk("first_BinOut", BinOut, 0);
    cyc(1'b0, G(5), 1'b1);
    chk("idle_BinOut", BinOut, 0);

    // Full count and wrap
    for (int b = 1; b < 8; b++) cyc(1'b1, G(b), 1'b0);
    chk("cnt_BinOut7", BinOut, 7);
    cyc(1'b1, G(0), 1'b1);
    chk("wrap_Wraps", Wraps, 1);
    chk("wrap_BinOut", BinOut, 0);
    chk("wrap_Err", Err, 0);

    // Upstream reset detection
    for (int b = 1; b < 6; b++) cyc(1'b1, G(b), 1'b1);
    chk("pre_resync_BinOut", BinOut, 5);
    cyc(1'b1, G(0), 1'b0);
    chk("resync_Resyncs", Resyncs, 1);
    chk("resync_Wraps", Wraps, 0);
    chk("resync_Err", Err, 0);

    // Jump error, frozen in ERR, Clear beats Valid, then unchecked resample
    cyc(1'b1, G(1), 1'b0);
    cyc(1'b1, G(2), 1'b0);
    cyc(1'b1, 3'b110, 1'b0);
    chk("jump_Err", Err, 1);
    chk("jump_ErrCode", ErrCode, 1);
    chk("jump_BinOut", BinOut, 2);
    cyc(1'b1, G(3), 1'b0);
    chk("errhold_BinOut", BinOut, 2);
    cyc(1'b1, G(7), 1'b1, 1'b1);
    chk("clr_Err", Err, 0);
    chk("clr_ErrCode", ErrCode, 0);
    chk("clr_drop_BinOut", BinOut, 2);
    cyc(1'b1, G(6), 1'b0);
    chk("reinit_BinOut", BinOut, 6);
    chk("reinit_Resyncs", Resyncs, 1);

    // OVF_EARLY then OVF_DROP
    cyc(1'b1, G(0), 1'b0);
    cyc(1'b1, G(1), 1'b0);
    cyc(1'b1, G(2), 1'b0);
    cyc(1'b1, G(3), 1'b1);
    chk("early_ErrCode", ErrCode, 2);
    chk("early_BinOut", BinOut, 2);
    cyc(1'b0, G(0), 1'b0, 1'b1);
    cyc(1'b1, G(3), 1'b1);
    cyc(1'b1, G(4), 1'b0);
    chk("drop_ErrCode", ErrCode, 3);
    chk("drop_BinOut", BinOut, 3);

    // Hold timeout
    cyc(1'b0, G(0), 1'b0, 1'b1);
    cyc(1'b1, G(0), 1'b0);
    cyc(1'b1, G(1), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, G(1), 1'b0);
    chk("hold3_Stall", Stall, 0);
    cyc(1'b1, G(1), 1'b0);
`ifdef GRAY_CHECKER_STALL_EN
    chk("hold4_Stall", Stall, 1);
    cyc(1'b0, G(4), 1'b0);
    chk("idle_Stall", Stall, 1);
`else
    chk("hold4_Stall", Stall, 0);
    cyc(1'b0, G(4), 1'b0);
`endif
    cyc(1'b1, G(2), 1'b0);
    chk("step_Stall", Stall, 0);

    // Resync saturation
    cyc(1'b1, G(0), 1'b0);
    for (int i = 0; i < 260; i++) begin
      cyc(1'b1, G(1), 1'b0);
      cyc(1'b1, G(0), 1'b0);
    end
    chk("sat_Resyncs", Resyncs, 255);

    // Wrap saturation
    for (int b = 1; b < 8; b++) cyc(1'b1, G(b), 1'b0);
    cyc(1'b1, G(0), 1'b1);
    for (int i = 0; i < 259; i++) begin
      for (int b = 1; b < 8; b++) cyc(1'b1, G(b), 1'b1);
      cyc(1'b1, G(0), 1'b1);
    end
    chk("sat_Wraps", Wraps, 255);
    chk("sat_Resyncs_kept", Resyncs, 255);
    chk("sat_Err", Err, 0);

    // Reset wins over Clear and Valid
    cyc(1'b1, G(1), 1'b1, 1'b1, 1'b0);
    chk("rst2_Wraps", Wraps, 0);
    chk("rst2_Resyncs", Resyncs, 0);
    chk("rst2_BinOut", BinOut, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
